// File: rtl/retire_rat_pkg.sv
// Shared types for the commit-side retirement RAT.
// The retire_rat file header names the optional RETIRE_PERF_EN counters.
package rv32i_types;
   localparam int NUM_REGS = 64;
   localparam int NUM_ARCH = 32;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RESTORE = 1'b1
   } retire_state_t;

   typedef struct packed {
      logic [4:0]                  arch;
      logic [$clog2(NUM_REGS)-1:0] phys;
   } restore_beat_t;
endpackage

// File: rtl/retire_rat_if.sv
// Commit, free-list and restore signals between the ROB/frontend and retire_rat.
interface retire_rat_if #(parameter int PW = 6);
   logic          valid_commit;
   logic [4:0]    commit_arch_rd;
   logic [PW-1:0] commit_phys_rd;
   logic          flush;
   logic          commit_ready;
   logic          free_valid;
   logic [PW-1:0] free_preg;
   logic          free_ready;
   logic          restore_valid;
   logic [4:0]    restore_arch;
   logic [PW-1:0] restore_phys;
   logic          restore_busy;
   logic [31:0]   retire_count;
   logic [31:0]   flush_count;

   modport slave (
      input  valid_commit, commit_arch_rd, commit_phys_rd, flush, free_ready,
      output commit_ready, free_valid, free_preg,
      output restore_valid, restore_arch, restore_phys, restore_busy,
      output retire_count, flush_count
   );

   modport master (
      output valid_commit, commit_arch_rd, commit_phys_rd, flush, free_ready,
      input  commit_ready, free_valid, free_preg,
      input  restore_valid, restore_arch, restore_phys, restore_busy,
      input  retire_count, flush_count
   );
endinterface

// File: rtl/retire_rat_preg_free_fifo.sv
// Small FIFO of physical register ids; a push into a full queue is taken
// only when a pop happens in the same cycle.
module preg_free_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   output logic         full_o,
   input  logic         pop_i,
   output logic [W-1:0] pop_data_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [AW:0]             wr_q, rd_q;
   logic                    do_pop, do_push;

   // Extra MSB on each pointer separates full from empty.
   assign empty_o    = (wr_q == rd_q);
   assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop     = pop_i & ~empty_o;
   assign do_push    = push_i & (~full_o | do_pop);
   assign pop_data_o = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data_i;
            wr_q                <= wr_q + PTR_ONE;
         end
         if (do_pop) rd_q <= rd_q + PTR_ONE;
      end
   end
endmodule

// File: rtl/retire_rat.sv
// Retirement RAT: applies committed mappings, frees superseded pregs and streams
// the map to the frontend after a flush. RETIRE_PERF_EN adds retire/flush counters.
module retire_rat #(
   parameter int NUM_REGS     = rv32i_types::NUM_REGS,
   parameter int FREE_Q_DEPTH = 4,
   localparam int PW          = $clog2(NUM_REGS)
) (
   input  logic         clk,
   input  logic         rst,
   retire_rat_if.slave  bus
);
   import rv32i_types::*;

   localparam logic [0:0] S_IDLE    = IDLE;
   localparam logic [0:0] S_RESTORE = RESTORE;

   logic [0:0]           state_q, state_d;
   logic [4:0]           idx_q, idx_d;
   logic [31:0][PW-1:0]  rrat_q, rrat_d;
   logic                 fifo_full, fifo_empty, pop, push, accept;
   logic [PW-1:0]        head;

   assign pop              = ~fifo_empty & bus.free_ready;
   assign bus.commit_ready = ~fifo_full | pop;
   // Commits during a restore walk are ignored so the streamed map stays stable.
   assign accept           = bus.valid_commit & bus.commit_ready & (state_q == S_IDLE);
   assign push             = accept & (bus.commit_arch_rd != 5'd0);
   assign bus.free_valid   = ~fifo_empty;
   assign bus.free_preg    = head;

   preg_free_fifo #(.DEPTH(FREE_Q_DEPTH), .W(PW)) u_free_q (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_data_i(rrat_q[bus.commit_arch_rd]),
      .full_o     (fifo_full),
      .pop_i      (pop),
      .pop_data_o (head),
      .empty_o    (fifo_empty)
   );

   always_comb begin
      rrat_d = rrat_q;
      if (push) rrat_d[bus.commit_arch_rd] = bus.commit_phys_rd;
   end

   // A flush always (re)starts the walk at index 1; index 0 is hardwired.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (bus.flush) begin
         state_d = S_RESTORE;
         idx_d   = 5'd1;
      end else if (state_q == S_RESTORE) begin
         if (idx_q == 5'd31) begin
            state_d = S_IDLE;
            idx_d   = 5'd0;
         end else begin
            idx_d = idx_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= 5'd0;
         for (int i = 0; i < 32; i++) rrat_q[i] <= PW'(i);
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rrat_q  <= rrat_d;
      end
   end

   assign bus.restore_valid = (state_q == S_RESTORE);
   assign bus.restore_busy  = (state_q == S_RESTORE);
   assign bus.restore_arch  = idx_q;
   assign bus.restore_phys  = rrat_q[idx_q];

`ifdef RETIRE_PERF_EN
   logic [31:0] retire_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retire_cnt_q <= 32'd0;
         flush_cnt_q  <= 32'd0;
      end else begin
         if (accept)    retire_cnt_q <= retire_cnt_q + 32'd1;
         if (bus.flush) flush_cnt_q  <= flush_cnt_q + 32'd1;
      end
   end

   assign bus.retire_count = retire_cnt_q;
   assign bus.flush_count  = flush_cnt_q;
`else
   assign bus.retire_count = 32'd0;
   assign bus.flush_count  = 32'd0;
`endif

`ifndef SYNTHESIS
   a_commit_when_ready: assert property (@(posedge clk) disable iff (!rst)
      bus.valid_commit |-> bus.commit_ready);
   a_no_commit_in_restore: assert property (@(posedge clk) disable iff (!rst)
      bus.valid_commit |-> (state_q == S_IDLE));
`endif
endmodule
